// File: rtl/fmul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fmul_result_buffer
// Description : Result buffer behind the 24-bit float multiplier (1 sign,
//               7 exponent, 16 mantissa bits). Tracks which multiplier slots
//               carry real operands, captures the matching result plus
//               overflow/underflow flags into a first-word-fall-through FIFO,
//               and presents the head on a valid/ready interface. Operand
//               issue is throttled by credits, so every issued result is
//               guaranteed a FIFO slot.
//
// Ports       : clk, rst                - clock, synchronous active-high reset
//               issue_valid/issue_ready - upstream operand issue handshake
//               res_float/res_overflow/
//               res_underflow           - multiplier outputs (LATENCY after issue)
//               out_valid/out_ready     - result handshake toward consumer
//               out_float/out_overflow/
//               out_underflow           - FIFO head result and flags
//               occupancy               - number of stored entries
//
// Options     : FMUL_FTZ_EN - when defined, entries pushed with underflow set
//               store a signed zero {sign, 23'b0} instead of res_float.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_result_buffer #(
  parameter int LATENCY = 4,   // issue-to-result cycles, 1..8
  parameter int DEPTH   = 8,   // FIFO entries, power of two, 2..32
  parameter int ADDR_W  = 3    // log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [23:0]       res_float,
  input  logic              res_overflow,
  input  logic              res_underflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_float,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic [ADDR_W:0]   occupancy
);

  localparam int INF_W   = $clog2(LATENCY + 1);
  // Wide enough to add occupancy and inflight without overflowing.
  localparam int SUM_W   = (((ADDR_W + 1) > INF_W) ? (ADDR_W + 1) : INF_W) + 1;
  localparam int ENTRY_W = 26;

  logic [LATENCY-1:0]  r_vpipe;
  logic [INF_W-1:0]    r_inflight;
  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W:0]     r_rd_ptr;
  logic [ENTRY_W-1:0]  r_mem [DEPTH];

  logic                w_issue_fire;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [SUM_W-1:0]    w_credit_used;
  logic [23:0]         w_store_float;
  logic [ENTRY_W-1:0]  w_head;

  // --------------------------------------------------------------------------
  // Handshakes and status decode (registers only, so issue_ready never
  // depends combinationally on issue_valid or out_ready).
  // --------------------------------------------------------------------------
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign occupancy = r_wr_ptr - r_rd_ptr;

  // A pop this cycle only lowers occupancy after the edge, so freed credit
  // becomes visible one cycle later.
  assign w_credit_used = SUM_W'(occupancy) + SUM_W'(r_inflight);
  assign issue_ready   = (w_credit_used < SUM_W'(DEPTH));

  assign w_issue_fire = issue_valid & issue_ready;
  assign w_push       = r_vpipe[LATENCY-1];
  assign out_valid    = !w_empty;
  // out_valid is zero when empty, so a pop can never hit an empty FIFO.
  assign w_pop        = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Stored word: optionally flush underflowed results to a signed zero.
  // --------------------------------------------------------------------------
`ifdef FMUL_FTZ_EN
  assign w_store_float = res_underflow ? {res_float[23], 23'b0} : res_float;
`else
  assign w_store_float = res_float;
`endif

  // --------------------------------------------------------------------------
  // Valid pipe, in-flight counter and FIFO pointers.
  // Clearing vpipe on reset is what discards results already in the
  // multiplier: their res_* values arrive later with no push slot marked.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe    <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_vpipe[0] <= w_issue_fire;
      for (int i = 1; i < LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end

      case ({w_issue_fire, w_push})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
      end
    end
  end

  // Storage array carries no reset; its content is only observed through
  // the pointers, which are reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {res_overflow, res_underflow, w_store_float};
    end
  end

  // --------------------------------------------------------------------------
  // First-word-fall-through head. Forced to zero while empty so the outputs
  // read zero out of reset; no bypass from push to the head in the same cycle.
  // --------------------------------------------------------------------------
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign {out_overflow, out_underflow, out_float} = w_head;

`ifndef SYNTHESIS
  // The credit rule makes a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full))
        else $error("fmul_result_buffer: push while FIFO full");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_result_buffer
// Description : Directed self-checking bench for fmul_result_buffer. A small
//               model of the multiplier returns each issued operand word as
//               the result LATENCY cycles later; idle slots return all-ones
//               so a spurious push shows up as wrong data. Expected results
//               are queued at issue time and compared at each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_result_buffer;

  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam int AW  = 3;

`ifdef FMUL_FTZ_EN
  localparam logic [23:0] EXP_UN_FLOAT = 24'h800000;
`else
  localparam logic [23:0] EXP_UN_FLOAT = 24'h80ABCD;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [23:0]   res_float;
  logic          res_overflow;
  logic          res_underflow;
  logic          out_valid;
  logic          out_ready;
  logic [23:0]   out_float;
  logic          out_overflow;
  logic          out_underflow;
  logic [AW:0]   occupancy;

  // Operand word presented with issue_valid: {overflow, underflow, float}
  logic [23:0]   iss_float;
  logic          iss_ov;
  logic          iss_un;

  logic [25:0]   mp [LAT];
  logic [25:0]   sbq [$];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fmul_result_buffer #(
    .LATENCY (LAT),
    .DEPTH   (DEP),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .res_float     (res_float),
    .res_overflow  (res_overflow),
    .res_underflow (res_underflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_float     (out_float),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .occupancy     (occupancy)
  );

  // Multiplier model: fixed latency, keeps running through reset.
  initial begin
    for (int i = 0; i < LAT; i++) mp[i] = 26'h3FFFFFF;
  end

  always @(posedge clk) begin
    mp[0] <= (issue_valid && issue_ready) ? {iss_ov, iss_un, iss_float} : 26'h3FFFFFF;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end

  assign {res_overflow, res_underflow, res_float} = mp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] exp_entry(input logic ov, input logic un, input logic [23:0] f);
`ifdef FMUL_FTZ_EN
    if (un) return {ov, un, f[23], 23'b0};
`endif
    return {ov, un, f};
  endfunction

  // Scoreboard the handshakes of the current cycle, then advance one clock.
  task automatic cycle();
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("pop_data", {6'b0, out_overflow, out_underflow, out_float}, {6'b0, sbq.pop_front()});
    end
    if (!rst && issue_valid && issue_ready) sbq.push_back(exp_entry(iss_ov, iss_un, iss_float));
    @(posedge clk);
    #1;
  endtask

  int accepted;
  int issued;
  int stalls;
  int max_occ;
  int n_valid;
  int first_v;
  int last_v;
  int cnt;

  initial begin
    rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0;
    iss_float = '0; iss_ov = 1'b0; iss_un = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;

    // ---- reset / idle state
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_float", out_float, 0);
    chk("rst_out_flags", {out_overflow, out_underflow}, 0);

    // ---- single issue, latency
    issue_valid = 1'b1; iss_float = 24'h412345;
    cycle();
    issue_valid = 1'b0;
    repeat (LAT - 1) cycle();
    chk("lat_not_yet", out_valid, 0);
    cycle();
    chk("lat_valid", out_valid, 1);
    chk("lat_float", out_float, 24'h412345);
    chk("lat_flags", {out_overflow, out_underflow}, 0);
    chk("lat_occ", occupancy, 1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("single_drain_occ", occupancy, 0);
    chk("single_drain_valid", out_valid, 0);

    // ---- credit fill with consumer stalled
    accepted = 0;
    issue_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      iss_float = 24'h000100 + 24'(accepted);
      if (issue_ready) accepted++;
      cycle();
    end
    issue_valid = 1'b0;
    chk("fill_accepted", accepted, DEP);
    chk("fill_ready_low", issue_ready, 0);
    chk("fill_occ", occupancy, DEP);
    chk("fill_head", out_float, 24'h000100);
    out_ready = 1'b1;
    repeat (10) cycle();
    chk("fill_drain_occ", occupancy, 0);
    chk("fill_drain_sb", sbq.size(), 0);

    // ---- streaming with consumer always ready
    issued = 0; stalls = 0; max_occ = 0; n_valid = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 30; k++) begin
      issue_valid = (issued < 20);
      iss_float = 24'(issued);
      if (issue_valid && !issue_ready) stalls++;
      if (issue_valid && issue_ready) issued++;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (out_valid) begin
        n_valid++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      cycle();
    end
    issue_valid = 1'b0;
    chk("stream_issued", issued, 20);
    chk("stream_stalls", stalls, 0);
    chk("stream_max_occ", max_occ, 1);
    chk("stream_n_valid", n_valid, 20);
    chk("stream_no_gap", last_v - first_v, 19);
    chk("stream_sb_empty", sbq.size(), 0);

    // ---- overflow / underflow flags
    out_ready = 1'b0;
    issue_valid = 1'b1;
    iss_float = 24'h7FFFFF; iss_ov = 1'b1; iss_un = 1'b0; cycle();
    iss_float = 24'h80ABCD; iss_ov = 1'b0; iss_un = 1'b1; cycle();
    iss_float = 24'h000001; iss_ov = 1'b0; iss_un = 1'b0; cycle();
    issue_valid = 1'b0;
    repeat (6) cycle();
    chk("flag_occ", occupancy, 3);
    chk("ovf_float", out_float, 24'h7FFFFF);
    chk("ovf_flags", {out_overflow, out_underflow}, 2'b10);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("unf_float", out_float, EXP_UN_FLOAT);
    chk("unf_flags", {out_overflow, out_underflow}, 2'b01);
    cycle();
    chk("unf_hold_float", out_float, EXP_UN_FLOAT);
    out_ready = 1'b1;
    cycle();
    chk("plain_flags", {out_overflow, out_underflow}, 2'b00);
    chk("plain_float", out_float, 24'h000001);
    cycle();
    chk("flag_drain_occ", occupancy, 0);

    // ---- reset with 2 stored and 3 in flight
    out_ready = 1'b0;
    issue_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iss_float = 24'h000200 + 24'(k);
      cycle();
    end
    issue_valid = 1'b0;
    cycle();
    chk("pre_rst_occ", occupancy, 2);
    rst = 1'b1;
    cycle();
    sbq.delete();
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", issue_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      if (out_valid) cnt++;
      cycle();
    end
    chk("post_rst_no_ghost", cnt, 0);
    chk("post_rst_occ", occupancy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmul_result_buffer.md
Name: fmul_result_buffer

Overview:
- Downstream stage of the 24-bit float multiplier pipeline (1 sign, 7 exponent, 16 mantissa bits).
- Tracks which pipeline slots carry real operands and captures the matching result and overflow/underflow flags into a small FIFO.
- Presents results on a valid/ready interface.
- Throttles operand issue with credit-based flow control, so an issued result always has a FIFO slot and is never lost.

Parameters:
- LATENCY, 4: cycles from operand presentation at the multiplier inputs to the matching result on its outputs; 1..8.
- DEPTH, 8: FIFO entries; power of two, 2..32.
- ADDR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  upstream presents an operand pair to the multiplier this cycle
- issue_ready  out  1  buffer can accept an issue this cycle
- res_float  in  24  multiplier result word
- res_overflow  in  1  multiplier overflow flag, aligned with res_float
- res_underflow  in  1  multiplier underflow flag, aligned with res_float
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer accepts the head
- out_float  out  24  head result word
- out_overflow  out  1  head overflow flag
- out_underflow  out  1  head underflow flag
- occupancy  out  ADDR_W+1  entries currently stored

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Handshakes:
  - issue_fire = issue_valid & issue_ready.
  - pop = out_valid & out_ready.
- Valid tracking:
  - LATENCY-bit shift register vpipe; vpipe[0] <= issue_fire each cycle, shifting toward vpipe[LATENCY-1].
  - push = vpipe[LATENCY-1].
  - An issue accepted at edge t is pushed at edge t+LATENCY using the res_* values present in that cycle.
- In-flight counter:
  - inflight (0..LATENCY): +1 on issue_fire, -1 on push; both in the same cycle leaves it unchanged.
- Credit rule:
  - issue_ready = (occupancy + inflight) < DEPTH, decoded from registers only.
  - issue_ready never depends combinationally on issue_valid or out_ready.
  - A pop frees credit from the next cycle, not the same cycle.
- FIFO:
  - Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - Each entry stores 26 bits: {overflow, underflow, float}.
  - First-word-fall-through: out_* show mem[rd_ptr] whenever out_valid = !empty.
  - out_* hold their value while out_valid & !out_ready.
- Boundary conditions:
  - Push and pop in the same cycle, FIFO non-empty: both happen; occupancy unchanged.
  - Push and pop in the same cycle, FIFO empty: no pop occurs; the pushed entry is visible next cycle, no bypass.
  - Push while full cannot occur because of the credit rule. Assertion (simulation only): push & full is an error.
  - Pop while empty is impossible, since out_valid = 0.
- Reset:
  - Pointers, vpipe, inflight and occupancy clear to 0.
  - issue_ready = 1, out_valid = 0, out_float = 0, out_overflow = 0, out_underflow = 0.
  - Results in flight at reset are discarded; their later res_* values are ignored.
- Throughput: one issue per cycle sustained while the consumer holds out_ready = 1.

Optional Feature:
- Macro: FMUL_FTZ_EN (flush-to-zero on underflow).
- With the macro defined: when a pushed entry has res_underflow = 1, the stored float is {res_float[23], 23'b0}, a signed zero. The underflow flag is still stored as 1.
- Without the macro: res_float is stored unmodified.
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then idle: issue_ready = 1, out_valid = 0, occupancy = 0; all outputs 0.
- Single issue at cycle 0; model drives res_float = 24'h412345 at cycle LATENCY (=4) -> out_valid rises at cycle 5 with out_float = 24'h412345, flags 0. Pop -> occupancy returns to 0.
- out_ready held 0, issue_valid held 1 -> exactly 8 issues accepted. issue_ready falls once occupancy + inflight = 8. Release out_ready -> 8 results drain in issue order.
- Streaming with out_ready = 1, 20 back-to-back issues with res_float = 24'h000000..24'h000013 -> outputs in order, no gaps after the first, occupancy never exceeds 1.
- res_overflow = 1 with res_float = 24'h7FFFFF -> out_overflow = 1 on that entry only. res_underflow = 1 with res_float = 24'h80ABCD -> stored 24'h80ABCD, or 24'h800000 when FMUL_FTZ_EN is defined.
- Assert rst while 3 results are in flight and 2 are stored -> next cycle occupancy = 0 and out_valid = 0. No entries appear from the discarded in-flight slots.
